// File: rtl/extbus_init_seq.sv
// Table-driven register initialiser for the external bus.
// Walks a {last, addr, data} table and issues one timed chip-select/write
// cycle per entry, optionally reading each register back to check it.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start                 run request, sampled only in IDLE
//   busy, done            run in progress / one-cycle completion pulse
//   error, err_idx        sticky read-back mismatch and failing entry index
//   tbl_rd, tbl_idx       table read strobe and index
//   tbl_entry             {last, addr, data}, valid the cycle after tbl_rd
//   extbus_*              chip select, strobes, address, data out/oe, data in
module extbus_init_seq #(
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1,
  parameter int unsigned VERIFY     = 0,
  parameter int unsigned AUTO_START = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [IDX_W-1:0]         err_idx,
  output logic                     tbl_rd,
  output logic [IDX_W-1:0]         tbl_idx,
  input  logic [ADDR_W+DATA_W:0]   tbl_entry,
  output logic                     extbus_cs_n,
  output logic                     extbus_rd_n,
  output logic                     extbus_wr_n,
  output logic [ADDR_W-1:0]        extbus_a,
  output logic [DATA_W-1:0]        extbus_d_out,
  output logic                     extbus_d_oe,
  input  logic [DATA_W-1:0]        extbus_d_in
);

  localparam int unsigned MAX_SW  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int unsigned MAX_CYC = (MAX_SW > HOLD_CYC) ? MAX_SW : HOLD_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(DEPTH - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_LOAD, S_SETUP, S_WSTROBE, S_WHOLD, S_RSTROBE, S_NEXT, S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                last_q, last_d;
  logic                auto_q, auto_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [IDX_W-1:0]    err_idx_q, err_idx_d;
  logic                tbl_rd_q, tbl_rd_d;
  logic [IDX_W-1:0]    tbl_idx_q, tbl_idx_d;
  logic                cs_n_q, cs_n_d;
  logic                rd_n_q, rd_n_d;
  logic                wr_n_q, wr_n_d;
  logic [ADDR_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   d_out_q, d_out_d;
  logic                d_oe_q, d_oe_d;

  // Next state; bus outputs are decoded from the next state so that every
  // output register reflects the state it belongs to in the same cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    last_d    = last_q;
    auto_d    = auto_q;
    error_d   = error_q;
    err_idx_d = err_idx_q;
    a_d       = a_q;
    d_out_d   = d_out_q;
    tbl_idx_d = tbl_idx_q;

    case (state_q)
      S_IDLE: begin
        if (start || ((AUTO_START != 0) && auto_q)) begin
          auto_d  = 1'b0;
          error_d = 1'b0;
          idx_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        last_d  = tbl_entry[ADDR_W+DATA_W];
        a_d     = tbl_entry[ADDR_W+DATA_W-1:DATA_W];
        d_out_d = tbl_entry[DATA_W-1:0];
        cnt_d   = '0;
        state_d = S_SETUP;
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          state_d = S_WSTROBE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WSTROBE: begin
        if (cnt_q == STROBE_LAST) begin
          cnt_d   = '0;
          state_d = S_WHOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WHOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = (VERIFY != 0) ? S_RSTROBE : S_NEXT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RSTROBE: begin
        // Read data is sampled on the final strobe cycle only.
        if (cnt_q == STROBE_LAST) begin
          cnt_d = '0;
          if (extbus_d_in != d_out_q) begin
            error_d   = 1'b1;
            err_idx_d = idx_q;
            state_d   = S_DONE;
          end else begin
            state_d = S_NEXT;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_NEXT: begin
        if (last_q || (idx_q == IDX_LAST)) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    tbl_rd_d = (state_d == S_FETCH);
    if (state_d == S_FETCH) tbl_idx_d = idx_d;
    cs_n_d = !((state_d == S_SETUP) || (state_d == S_WSTROBE) ||
               (state_d == S_WHOLD) || (state_d == S_RSTROBE));
    wr_n_d = (state_d != S_WSTROBE);
    rd_n_d = (state_d != S_RSTROBE);
    d_oe_d = (state_d == S_SETUP) || (state_d == S_WSTROBE) || (state_d == S_WHOLD);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      last_q    <= 1'b0;
      auto_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      err_idx_q <= '0;
      tbl_rd_q  <= 1'b0;
      tbl_idx_q <= '0;
      cs_n_q    <= 1'b1;
      rd_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      a_q       <= '0;
      d_out_q   <= '0;
      d_oe_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      auto_q    <= auto_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      err_idx_q <= err_idx_d;
      tbl_rd_q  <= tbl_rd_d;
      tbl_idx_q <= tbl_idx_d;
      cs_n_q    <= cs_n_d;
      rd_n_q    <= rd_n_d;
      wr_n_q    <= wr_n_d;
      a_q       <= a_d;
      d_out_q   <= d_out_d;
      d_oe_q    <= d_oe_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign err_idx      = err_idx_q;
  assign tbl_rd       = tbl_rd_q;
  assign tbl_idx      = tbl_idx_q;
  assign extbus_cs_n  = cs_n_q;
  assign extbus_rd_n  = rd_n_q;
  assign extbus_wr_n  = wr_n_q;
  assign extbus_a     = a_q;
  assign extbus_d_out = d_out_q;
  assign extbus_d_oe  = d_oe_q;

endmodule

// File: tb/tb_extbus_init_seq.sv
// Scoreboard bench for extbus_init_seq: three instances with different
// timing/verify settings; expected bus windows and done events are queued
// by the stimulus and popped by a negedge monitor.
module tb_extbus_init_seq;

  logic        clk;
  logic        reset_n;
  logic        start     [3];
  logic        busy      [3];
  logic        done      [3];
  logic        error     [3];
  logic [1:0]  err_idx   [3];
  logic        tbl_rd    [3];
  logic [1:0]  tbl_idx   [3];
  logic [13:0] tbl_entry [3];
  logic        cs_n      [3];
  logic        rd_n      [3];
  logic        wr_n      [3];
  logic [4:0]  a         [3];
  logic [7:0]  dout      [3];
  logic        d_oe      [3];
  logic [7:0]  din       [3];

  logic [13:0] tbl    [3][4];
  logic [7:0]  shadow [32];
  bit          bad_en;

  int nvec = 0;
  int nmis = 0;
  int cyc  = 0;

  typedef struct packed {
    logic [1:0] inst; logic [4:0] a; logic [7:0] d;
    logic [4:0] cs; logic [2:0] wr; logic [2:0] rd; logic stable;
  } win_t;
  typedef struct packed {
    logic [1:0] inst; logic err; logic [1:0] idx; logic [7:0] cyc;
  } dn_t;

  win_t wq[$];
  dn_t  dq[$];

  // monitor state
  bit         act[3];
  int         wlen[3], wwr[3], wrd[3], t0[3];
  logic [4:0] wa[3];
  logic [7:0] wd[3];
  bit         wstab[3], in_run[3], glitch[3], prev_done[3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // u0: default timing, auto start; u1: slow timing; u2: read-back verify
  extbus_init_seq #(.DEPTH(4)) u0 (
    .clk(clk), .reset_n(reset_n), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .error(error[0]), .err_idx(err_idx[0]), .tbl_rd(tbl_rd[0]), .tbl_idx(tbl_idx[0]),
    .tbl_entry(tbl_entry[0]), .extbus_cs_n(cs_n[0]), .extbus_rd_n(rd_n[0]),
    .extbus_wr_n(wr_n[0]), .extbus_a(a[0]), .extbus_d_out(dout[0]),
    .extbus_d_oe(d_oe[0]), .extbus_d_in(din[0]));

  extbus_init_seq #(.DEPTH(4), .SETUP_CYC(3), .STROBE_CYC(4), .HOLD_CYC(2),
                    .AUTO_START(0)) u1 (
    .clk(clk), .reset_n(reset_n), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .error(error[1]), .err_idx(err_idx[1]), .tbl_rd(tbl_rd[1]), .tbl_idx(tbl_idx[1]),
    .tbl_entry(tbl_entry[1]), .extbus_cs_n(cs_n[1]), .extbus_rd_n(rd_n[1]),
    .extbus_wr_n(wr_n[1]), .extbus_a(a[1]), .extbus_d_out(dout[1]),
    .extbus_d_oe(d_oe[1]), .extbus_d_in(din[1]));

  extbus_init_seq #(.DEPTH(4), .VERIFY(1), .AUTO_START(0)) u2 (
    .clk(clk), .reset_n(reset_n), .start(start[2]), .busy(busy[2]), .done(done[2]),
    .error(error[2]), .err_idx(err_idx[2]), .tbl_rd(tbl_rd[2]), .tbl_idx(tbl_idx[2]),
    .tbl_entry(tbl_entry[2]), .extbus_cs_n(cs_n[2]), .extbus_rd_n(rd_n[2]),
    .extbus_wr_n(wr_n[2]), .extbus_a(a[2]), .extbus_d_out(dout[2]),
    .extbus_d_oe(d_oe[2]), .extbus_d_in(din[2]));

  // table ROM model: entry valid the cycle after tbl_rd
  initial for (int i = 0; i < 3; i++) tbl_entry[i] = '0;
  always @(posedge clk)
    for (int i = 0; i < 3; i++)
      if (tbl_rd[i]) tbl_entry[i] <= tbl[i][tbl_idx[i]];

  // register file behind u2; address 0x07 optionally reads back as zero
  always @(posedge clk)
    if (!cs_n[2] && !wr_n[2]) shadow[a[2]] <= dout[2];
  assign din[0] = 8'h00;
  assign din[1] = 8'h00;
  assign din[2] = (bad_en && (a[2] == 5'h07)) ? 8'h00 : shadow[a[2]];

  function automatic logic [13:0] ent(input logic l, input logic [4:0] ad, input logic [7:0] d);
    return {l, ad, d};
  endfunction

  // expected window shape per instance: cs_n-low length, wr_n-low, rd_n-low
  task automatic push_win(input int i, input logic [4:0] ad, input logic [7:0] d);
    win_t w;
    w.inst = 2'(i); w.a = ad; w.d = d; w.stable = 1'b1;
    case (i)
      0:       begin w.cs = 5'd4;  w.wr = 3'd2; w.rd = 3'd0; end
      1:       begin w.cs = 5'd9;  w.wr = 3'd4; w.rd = 3'd0; end
      default: begin w.cs = 5'd6;  w.wr = 3'd2; w.rd = 3'd2; end
    endcase
    wq.push_back(w);
  endtask

  task automatic push_done(input int i, input logic e, input logic [1:0] ix, input logic [7:0] c);
    dn_t x;
    x.inst = 2'(i); x.err = e; x.idx = ix; x.cyc = c;
    dq.push_back(x);
  endtask

  task automatic check_win(input int i);
    win_t g, e;
    g.inst = 2'(i); g.a = wa[i]; g.d = wd[i]; g.cs = 5'(wlen[i]);
    g.wr = 3'(wwr[i]); g.rd = 3'(wrd[i]); g.stable = wstab[i];
    nvec++;
    if (wq.size() == 0) begin
      nmis++;
      $display("FAIL unexpected_win inst%0d: got a=%h d=%h cs=%0d, required no window", i, g.a, g.d, g.cs);
    end else begin
      e = wq.pop_front();
      if (g != e) begin
        nmis++;
        $display("FAIL win inst%0d: got a=%h d=%h cs=%0d wr=%0d rd=%0d stable=%0d, required inst%0d a=%h d=%h cs=%0d wr=%0d rd=%0d stable=1",
                 i, g.a, g.d, g.cs, g.wr, g.rd, g.stable, e.inst, e.a, e.d, e.cs, e.wr, e.rd);
      end
    end
  endtask

  task automatic check_done(input int i);
    dn_t g, e;
    g.inst = 2'(i); g.err = error[i]; g.idx = error[i] ? err_idx[i] : 2'b00;
    g.cyc = 8'(cyc - t0[i]);
    in_run[i] = 1'b0;
    nvec++;
    if (dq.size() == 0) begin
      nmis++;
      $display("FAIL unexpected_done inst%0d: got done, required none", i);
    end else begin
      e = dq.pop_front();
      if (g != e || glitch[i]) begin
        nmis++;
        $display("FAIL done inst%0d: got err=%0d idx=%0d cyc=%0d bus_rule_violation=%0d, required inst%0d err=%0d idx=%0d cyc=%0d bus_rule_violation=0",
                 i, g.err, g.idx, g.cyc, glitch[i], e.inst, e.err, e.idx, e.cyc);
      end
    end
  endtask

  // monitor: rebuilds bus windows and done events, checks bus rules
  always @(negedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < 3; i++) begin
      if (!reset_n) begin
        act[i] = 1'b0; in_run[i] = 1'b0; prev_done[i] = 1'b0;
      end else begin
        if ((cs_n[i] && (!wr_n[i] || !rd_n[i])) || (!wr_n[i] && !rd_n[i]) ||
            (!rd_n[i] && d_oe[i]))
          glitch[i] = 1'b1;
        if (tbl_rd[i] && !in_run[i]) begin
          in_run[i] = 1'b1; t0[i] = cyc;
        end
        if (!cs_n[i]) begin
          if (!act[i]) begin
            act[i] = 1'b1; wa[i] = a[i]; wd[i] = dout[i];
            wlen[i] = 0; wwr[i] = 0; wrd[i] = 0; wstab[i] = 1'b1;
          end
          wlen[i]++;
          if (!wr_n[i]) wwr[i]++;
          if (!rd_n[i]) wrd[i]++;
          if (a[i] != wa[i] || dout[i] != wd[i]) wstab[i] = 1'b0;
        end else if (act[i]) begin
          act[i] = 1'b0;
          check_win(i);
        end
        if (prev_done[i]) begin
          nvec++;
          if (busy[i] !== 1'b0) begin
            nmis++;
            $display("FAIL busy_after_done inst%0d: got %0d, required 0", i, busy[i]);
          end
        end
        if (done[i]) check_done(i);
        prev_done[i] = done[i];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    nvec++;
    if (got !== req) begin
      nmis++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic pulse_start(input int i);
    start[i] = 1'b1;
    @(posedge clk); #1;
    start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int maxc);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < maxc && !seen; k++) begin
      @(posedge clk); #1;
      if (done[i]) seen = 1'b1;
    end
    check($sformatf("done_seen_inst%0d", i), 32'(seen), 32'd1);
  endtask

  initial begin
    bit seen;
    reset_n = 1'b0;
    bad_en  = 1'b0;
    for (int i = 0; i < 3; i++) start[i] = 1'b0;
    tbl[0][0] = ent(0, 5'h00, 8'hA5); tbl[0][1] = ent(0, 5'h01, 8'h5A);
    tbl[0][2] = ent(1, 5'h1F, 8'hFF); tbl[0][3] = ent(0, 5'h0A, 8'h0B);
    tbl[1][0] = ent(0, 5'h03, 8'h3C); tbl[1][1] = ent(1, 5'h10, 8'hC3);
    tbl[1][2] = ent(0, 5'h11, 8'h11); tbl[1][3] = ent(0, 5'h12, 8'h12);
    tbl[2][0] = ent(0, 5'h02, 8'h11); tbl[2][1] = ent(0, 5'h07, 8'h22);
    tbl[2][2] = ent(1, 5'h1E, 8'h33); tbl[2][3] = ent(0, 5'h15, 8'h44);

    // reset values
    repeat (3) @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_ctl_inst%0d", i),
            32'({cs_n[i], rd_n[i], wr_n[i], d_oe[i], busy[i], done[i], error[i], tbl_rd[i]}),
            32'h0000_00E0);
      check($sformatf("reset_data_inst%0d", i),
            32'({a[i], dout[i], err_idx[i], tbl_idx[i]}), 32'h0);
    end

    // auto start after reset: three entries, last flag on entry 2
    push_win(0, 5'h00, 8'hA5); push_win(0, 5'h01, 8'h5A); push_win(0, 5'h1F, 8'hFF);
    push_done(0, 1'b0, 2'd0, 8'd21);
    reset_n = 1'b1;
    wait_done(0, 100);

    // no last flag: stops at index 3, mid-run start ignored
    tbl[0][0] = ent(0, 5'h04, 8'h40); tbl[0][1] = ent(0, 5'h05, 8'h50);
    tbl[0][2] = ent(0, 5'h06, 8'h60); tbl[0][3] = ent(0, 5'h07, 8'h70);
    repeat (2) @(posedge clk); #1;
    for (int r = 0; r < 2; r++) begin
      push_win(0, 5'h04, 8'h40); push_win(0, 5'h05, 8'h50);
      push_win(0, 5'h06, 8'h60); push_win(0, 5'h07, 8'h70);
      push_done(0, 1'b0, 2'd0, 8'd28);
    end
    pulse_start(0);
    repeat (10) @(posedge clk); #1;
    pulse_start(0);
    wait_done(0, 100);
    // start held through DONE and the following IDLE: only the IDLE one counts
    start[0] = 1'b1;
    @(posedge clk); #1;
    check("idle_after_done", 32'({busy[0], tbl_rd[0]}), 32'h0);
    @(posedge clk); #1;
    start[0] = 1'b0;
    check("restart_fetch", 32'({tbl_rd[0], tbl_idx[0], busy[0]}), 32'h9);
    wait_done(0, 100);
    // start only in the DONE cycle: ignored
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("done_start_ignored", 32'({busy[0], tbl_rd[0]}), 32'h0);
      @(posedge clk); #1;
    end

    // slow timing: 9-cycle cs_n window, 4-cycle write strobe
    push_win(1, 5'h03, 8'h3C); push_win(1, 5'h10, 8'hC3);
    push_done(1, 1'b0, 2'd0, 8'd24);
    pulse_start(1);
    wait_done(1, 200);

    // verify: entry 1 reads back wrong, run aborts before entry 2
    bad_en = 1'b1;
    push_win(2, 5'h02, 8'h11); push_win(2, 5'h07, 8'h22);
    push_done(2, 1'b1, 2'd1, 8'd17);
    pulse_start(2);
    wait_done(2, 200);
    repeat (3) @(posedge clk); #1;
    check("error_sticky", 32'({error[2], err_idx[2]}), 32'h5);
    bad_en = 1'b0;
    push_win(2, 5'h02, 8'h11); push_win(2, 5'h07, 8'h22); push_win(2, 5'h1E, 8'h33);
    push_done(2, 1'b0, 2'd0, 8'd27);
    pulse_start(2);
    check("error_cleared", 32'({error[2], busy[2]}), 32'h1);
    wait_done(2, 200);

    // async reset during the write strobe, then auto restart from index 0
    tbl[0][0] = ent(0, 5'h00, 8'hA5); tbl[0][1] = ent(0, 5'h01, 8'h5A);
    tbl[0][2] = ent(1, 5'h1F, 8'hFF);
    repeat (2) @(posedge clk); #1;
    pulse_start(0);
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      if (!wr_n[0]) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("wstrobe_seen", 32'(seen), 32'd1);
    #2 reset_n = 1'b0;
    #1 check("async_reset", 32'({cs_n[0], wr_n[0], d_oe[0], busy[0]}), 32'hC);
    push_win(0, 5'h00, 8'hA5); push_win(0, 5'h01, 8'h5A); push_win(0, 5'h1F, 8'hFF);
    push_done(0, 1'b0, 2'd0, 8'd21);
    @(posedge clk); #1;
    reset_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(posedge clk); #1;
      if (tbl_rd[0]) seen = 1'b1;
    end
    check("restart_idx0", 32'({seen, tbl_idx[0]}), 32'h4);
    wait_done(0, 100);

    repeat (20) @(posedge clk); #1;
    check("queues_drained", 32'(wq.size() + dq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
